// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned ITERS   = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_e;

    // Two's-complement magnitude; MIN_INT maps to 2^31 read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// Operand/command and result/status bundle between the execute stage and the unit.
interface multdiv_if;
    import multdiv_pkg::*;

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/multdiv_counter.sv
// Iteration counter: cleared at every start, saturates at ITERS, flags the last step.
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next count: clear wins, otherwise step up to ITERS and hold there
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < CNT_W'(ITERS))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiplier/divider sharing one shift register and one adder.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset_n,
    multdiv_if.slave bus
);

    state_e             state_q, state_d;
    logic               start_mul, start_div, start;
    logic               step_en, tc, div_zero, busy;
    logic [2*WIDTH-1:0] acc_q, acc_d, signed_acc;
    logic [WIDTH-1:0]   opb_q, opb_d, result_q, result_d;
    logic               neg_q, neg_d, is_mul_q, is_mul_d;
    logic               exc_q, exc_d, rdy_q, rdy_d;
    logic [WIDTH-1:0]   add_a, add_b;
    logic               add_cin;
    logic [WIDTH:0]     sum;
    logic               mul_ovf, div_ovf;

    // Both strobes high at once is not a command
    assign start_mul = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign start     = start_mul | start_div;
    assign step_en   = (state_q == StMul) || (state_q == StDiv);
    assign div_zero  = (opb_q == '0);

    multdiv_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .clr_i  (start),
        .en_i   (step_en),
        .tc_o   (tc)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a valid start always restarts, aborting any op in flight
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = start_mul ? StMul : StDiv;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StMul:  if (tc) state_d = StDone;
                StDiv: begin
                    if (div_zero) begin
                        state_d = StIdle;
                    end else if (tc) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Shared 33-bit adder: add multiplicand (MUL) or subtract divisor (DIV)
    always_comb begin
        add_a   = is_mul_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-2:WIDTH-1];
        add_b   = is_mul_q ? opb_q : ~opb_q;
        add_cin = ~is_mul_q;
        sum     = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    end

    // Sign fix-up and overflow detection on the finished magnitude
    always_comb begin
        signed_acc = neg_q ? ('0 - acc_q) : acc_q;
        mul_ovf    = ~((&signed_acc[2*WIDTH-1:WIDTH-1]) | ~(|signed_acc[2*WIDTH-1:WIDTH-1]));
        // Only a positive quotient of magnitude 2^31 (MIN_INT / -1) overflows
        div_ovf    = ~neg_q & (acc_q[WIDTH-1:0] == MIN_INT);
    end

    // Datapath next values
    always_comb begin
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        is_mul_d = is_mul_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (start) begin
            acc_d    = {{WIDTH{1'b0}}, abs_val(bus.data_operandA)};
            opb_d    = abs_val(bus.data_operandB);
            neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            is_mul_d = start_mul;
        end else begin
            unique case (state_q)
                StMul: begin
                    // Shift-add: low half holds the remaining multiplier bits
                    acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
                end
                StDiv: begin
                    if (div_zero) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
                    end else begin
                        // Restoring step: carry out set means the trial subtract fit
                        acc_d = sum[WIDTH] ? {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                           : {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end
                StDone: begin
                    result_d = signed_acc[WIDTH-1:0];
                    exc_d    = is_mul_q ? mul_ovf : div_ovf;
                    rdy_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            is_mul_q <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            is_mul_q <= is_mul_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy;

endmodule
